// File: rtl/elevator_scheduler.sv
// SCAN (collective) elevator scheduler: latches cabin and hall calls, tracks the
// car position from the floor sensors and sequences the motor and the door.
module elevator_scheduler #(
   parameter int NUM_FLOORS  = 3,
   parameter int DOOR_CYCLES = 4,
   localparam int FW = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] floor_sensor,
   input  logic [NUM_FLOORS-1:0] car_call,
   input  logic [NUM_FLOORS-1:0] hall_up,
   input  logic [NUM_FLOORS-1:0] hall_dn,
   output logic [1:0]            motor,
   output logic [FW-1:0]         cur_floor,
   output logic                  door_open,
   output logic                  dir_up,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(DOOR_CYCLES - 1);
   localparam logic [FW-1:0] TOP = FW'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] UP_OK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
   localparam logic [NUM_FLOORS-1:0] DN_OK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

   function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FW-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
      return m;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FW-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
      return m;
   endfunction

   function automatic logic [FW-1:0] sensor_index(input logic [NUM_FLOORS-1:0] s);
      logic [FW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_FLOORS; i++) if (s[i]) idx = FW'(i);
      return idx;
   endfunction

   state_t                  state, state_nxt;
   logic [NUM_FLOORS-1:0]   up_req, dn_req, car_req;
   logic [NUM_FLOORS-1:0]   up_nxt, dn_nxt, car_nxt, all_req;
   logic [NUM_FLOORS-1:0]   set_up, set_dn, set_car, clr_up, clr_dn, clr_car;
   logic [FW-1:0]           floor_nxt, svc_floor, k;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic                    dir_nxt, enter, svc_up, beyond, hold, sensor_ok;
   logic                    req_above, req_below;

   always_comb begin
      state_nxt = state;
      floor_nxt = cur_floor;
      dir_nxt   = dir_up;
      cnt_nxt   = cnt;
      all_req   = up_req | dn_req | car_req;
      set_car   = car_call;
      set_up    = hall_up & UP_OK;
      set_dn    = hall_dn & DN_OK;
      clr_up    = '0;
      clr_dn    = '0;
      clr_car   = '0;
      enter     = 1'b0;
      svc_floor = cur_floor;
      svc_up    = dir_up;
      beyond    = 1'b0;
      hold      = 1'b0;
      sensor_ok = $onehot(floor_sensor);
      k         = sensor_index(floor_sensor);
      req_above = |(all_req & above_mask(cur_floor));
      req_below = |(all_req & below_mask(cur_floor));

      // With the door open, a call already being served at this floor only keeps the door open.
      if (state == DOOR) begin
         hold = car_call[cur_floor] | (dir_up ? set_up[cur_floor] : set_dn[cur_floor]);
         set_car[cur_floor] = 1'b0;
         if (dir_up) set_up[cur_floor] = 1'b0;
         else        set_dn[cur_floor] = 1'b0;
      end

      case (state)
         IDLE: begin
            if (all_req[cur_floor]) begin
               enter  = 1'b1;
               svc_up = ~(dn_req[cur_floor] & ~up_req[cur_floor] & ~car_req[cur_floor]);
            end else if (req_above) begin
               state_nxt = MOVE_UP;
               dir_nxt   = 1'b1;
            end else if (req_below) begin
               state_nxt = MOVE_DN;
               dir_nxt   = 1'b0;
            end
         end
         MOVE_UP: begin
            if (sensor_ok) begin
               floor_nxt = k;
               if (car_req[k] || up_req[k] || !(|(all_req & above_mask(k))) || k == TOP) begin
                  enter     = 1'b1;
                  svc_floor = k;
                  svc_up    = 1'b1;
               end
            end
         end
         MOVE_DN: begin
            if (sensor_ok) begin
               floor_nxt = k;
               if (car_req[k] || dn_req[k] || !(|(all_req & below_mask(k))) || k == '0) begin
                  enter     = 1'b1;
                  svc_floor = k;
                  svc_up    = 1'b0;
               end
            end
         end
         DOOR: begin
            if (hold) begin
               cnt_nxt = LOAD;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (dir_up ? req_above : req_below) begin
               state_nxt = dir_up ? MOVE_UP : MOVE_DN;
            end else if (dir_up ? req_below : req_above) begin
               dir_nxt   = ~dir_up;
               state_nxt = dir_up ? MOVE_DN : MOVE_UP;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A stop at the end of the sweep also serves the opposite hall call and reverses.
      if (enter) begin
         beyond = svc_up ? |(all_req & above_mask(svc_floor)) : |(all_req & below_mask(svc_floor));
         clr_car[svc_floor] = 1'b1;
         if (svc_up || !beyond) clr_up[svc_floor] = 1'b1;
         if (!svc_up || !beyond) clr_dn[svc_floor] = 1'b1;
         dir_nxt   = beyond ? svc_up : ~svc_up;
         state_nxt = DOOR;
         cnt_nxt   = LOAD;
      end

      up_nxt  = (up_req & ~clr_up) | set_up;
      dn_nxt  = (dn_req & ~clr_dn) | set_dn;
      car_nxt = (car_req & ~clr_car) | set_car;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         up_req    <= '0;
         dn_req    <= '0;
         car_req   <= '0;
         cnt       <= '0;
         motor     <= 2'b00;
         cur_floor <= '0;
         door_open <= 1'b0;
         dir_up    <= 1'b1;
         pending   <= '0;
      end else begin
         state     <= state_nxt;
         up_req    <= up_nxt;
         dn_req    <= dn_nxt;
         car_req   <= car_nxt;
         cnt       <= cnt_nxt;
         motor     <= (state_nxt == MOVE_UP) ? 2'b01 : (state_nxt == MOVE_DN) ? 2'b10 : 2'b00;
         cur_floor <= floor_nxt;
         door_open <= (state_nxt == DOOR);
         dir_up    <= dir_nxt;
         pending   <= up_nxt | dn_nxt | car_nxt;
      end
   end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Request-latching SCAN (collective) scheduler that sequences the elevator car.
- Latches cabin calls and hall up/down calls, tracks the current floor from the floor sensors and drives the motor command and the door.
- Sits between the button/sensor inputs and the motor/door/display drivers, and replaces ad-hoc per-floor decoding with a parameterised controller.

Parameters:
NUM_FLOORS, 3, number of floors (>=2); floor index 0 is the bottom floor.
DOOR_CYCLES, 4, clock cycles the door stays open per stop (>=1).
FW, $clog2(NUM_FLOORS), floor index width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
floor_sensor  input  NUM_FLOORS  one-hot; bit k high = car at floor k.
car_call  input  NUM_FLOORS  cabin floor buttons.
hall_up  input  NUM_FLOORS  hall up buttons; top bit ignored.
hall_dn  input  NUM_FLOORS  hall down buttons; bit 0 ignored.
motor  output  2  00 stop, 01 up, 10 down (11 never driven).
cur_floor  output  FW  current or last-passed floor (display).
door_open  output  1  door command.
dir_up  output  1  scan direction; 1 = up.
pending  output  NUM_FLOORS  OR of latched requests per floor.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides everything.
- Reset values: state IDLE, all request registers 0, motor=00, cur_floor=0, door_open=0, dir_up=1, pending=0, door counter 0.
- Reset mid-move: the same reset values apply. The car position is assumed to be floor 0.
- Outputs: all outputs are registered.
- Input sampling: inputs are sampled on rising clk. A button must be high at at least one edge; pulses shorter than a cycle are the caller's problem.
- Request registers: up_req, dn_req and car_req are set on input high and held until served. Set and clear of the same bit in one cycle: clear wins only under the door-open suppression rule below; otherwise set wins.
- Sensor handling: floor_sensor is used only in MOVE_UP/MOVE_DN. If it is not one-hot it is ignored for that cycle. When valid, cur_floor is loaded with the sensor index, adjacency unchecked.
- "Above" / "below": any request bit (any type) at an index strictly greater / less than cur_floor.
- FSM states: IDLE, MOVE_UP, MOVE_DN, DOOR.
- IDLE, request at cur_floor:
  - Go to DOOR.
  - Service direction: up if up_req[cur] or car_req[cur] with no dn_req[cur]; down if only dn_req[cur].
- IDLE, otherwise:
  - If above: go to MOVE_UP, dir_up=1.
  - Else if below: go to MOVE_DN, dir_up=0.
  - Else stay in IDLE.
  - Requests present at edge T give motor=01 or 10 after edge T+1.
- MOVE_UP (motor=01), valid sensor k: stop if any of the following hold:
  - car_req[k];
  - up_req[k];
  - no request above k;
  - k==NUM_FLOORS-1.
  On a stop: same edge, motor=00, door_open=1, state DOOR. Otherwise keep moving.
- MOVE_DN: mirror image of MOVE_UP, using dn_req, "below" and k==0.
- Entering DOOR at floor k with direction D:
  - Clear car_req[k] and the hall request in direction D at k.
  - If there is no request beyond k in D, also clear the opposite hall request at k and flip dir_up.
  - Load the counter; door_open is high for exactly DOOR_CYCLES cycles.
- During DOOR, suppression: new car_call[k] or a hall call at k matching dir_up is not latched and reloads the counter, which extends the door. A mismatched hall call at k latches normally.
- DOOR expiry:
  - If there is a request in dir_up: move that way.
  - Else if there is a request opposite: flip dir_up and move.
  - Else go to IDLE.
  - door_open falls on the same edge that motor is asserted.
- Never: motor non-zero while door_open=1.
- pending: registered copy, reflecting request registers after the current edge.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs -> motor=00, cur_floor=0, door_open=0, dir_up=1, pending=000. rst asserted during MOVE_UP -> same values next edge.
2. Idle at floor 0: hall_up[1] 1 cycle at edge T -> pending=010, motor=01 after T+1. Sensor 010 -> cur_floor=1, motor=00, door_open=1 for 4 cycles -> IDLE, pending=000.
3. At floor 0: car_call[2], then hall_dn[1] while moving -> pass floor 1 without stopping. Stop at 2 and door opens; dir_up flips to 0. After 4 cycles motor=10; stop at 1 and clear dn_req[1], pending=000.
4. Idle at floor 1: car_call[1] -> door_open=1 with motor=00 throughout; no motion.
5. Door open at floor 1 going up: car_call[1] on door cycle 3 -> door_open extended to 3+4 cycles total. hall_dn[1] in the same window -> latched, pending[1]=1.
6. Sensor glitch: floor_sensor=011 while MOVE_UP -> ignored, cur_floor unchanged, motor stays 01.
